// File: rtl/std_pair_streamer.sv
// Pair FIFO feeding the std_x/std_y channels of the contrast comparator; keeps x/y halves aligned per pair.
// Optional stall counter enabled by defining SSIM_STD_STALL_CNT_EN.
module std_pair_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] std_x,
    output logic                  std_x_valid,
    input  logic                  std_x_ready,
    output logic [DATA_WIDTH-1:0] std_y,
    output logic                  std_y_valid,
    input  logic                  std_y_ready,
`ifdef SSIM_STD_STALL_CNT_EN
    input  logic                  stall_clr,
    output logic [15:0]           stall_cycles,
`endif
    output logic [ADDR_WIDTH:0]   fifo_count
);

    typedef enum logic [1:0] {
        PAIR_IDLE   = 2'b00,
        PAIR_X_SENT = 2'b01,
        PAIR_Y_SENT = 2'b10
    } pair_state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL   = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_x_r [DEPTH];
    logic [DATA_WIDTH-1:0] mem_y_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    pair_state_t           pair_state_r;

    logic                  not_empty_s;
    logic                  x_done_s;
    logic                  y_done_s;
    logic                  x_fire_s;
    logic                  y_fire_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;

    assign not_empty_s = (count_r != CNT_ZERO);
    assign x_done_s    = (pair_state_r == PAIR_X_SENT);
    assign y_done_s    = (pair_state_r == PAIR_Y_SENT);

    // Outputs are pure functions of registered state; data is gated to zero while empty.
    assign in_ready    = (count_r != CNT_FULL);
    assign std_x_valid = not_empty_s & ~x_done_s;
    assign std_y_valid = not_empty_s & ~y_done_s;
    assign std_x       = not_empty_s ? mem_x_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign std_y       = not_empty_s ? mem_y_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign fifo_count  = count_r;

    assign x_fire_s = std_x_valid & std_x_ready;
    assign y_fire_s = std_y_valid & std_y_ready;
    assign push_s   = in_valid & in_ready;
    // A pair retires once each half has either fired now or fired earlier.
    assign pop_s    = not_empty_s & (x_fire_s | x_done_s) & (y_fire_s | y_done_s);

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pair storage is intentionally not reset; unread entries are never exposed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_x_r[wr_ptr_r] <= in_x;
            mem_y_r[wr_ptr_r] <= in_y;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Per-pair handshake tracker: remembers which half of the head pair has already gone out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_state_r <= PAIR_IDLE;
        end else if (pop_s) begin
            pair_state_r <= PAIR_IDLE;
        end else begin
            case (pair_state_r)
                PAIR_IDLE: begin
                    if (x_fire_s) begin
                        pair_state_r <= PAIR_X_SENT;
                    end else if (y_fire_s) begin
                        pair_state_r <= PAIR_Y_SENT;
                    end else begin
                        pair_state_r <= PAIR_IDLE;
                    end
                end
                PAIR_X_SENT: pair_state_r <= PAIR_X_SENT;
                PAIR_Y_SENT: pair_state_r <= PAIR_Y_SENT;
                default:     pair_state_r <= PAIR_IDLE;
            endcase
        end
    end

`ifdef SSIM_STD_STALL_CNT_EN
    logic [15:0] stall_cycles_r;
    logic        stall_s;

    assign stall_s      = (std_x_valid & ~std_x_ready) | (std_y_valid & ~std_y_ready);
    assign stall_cycles = stall_cycles_r;

    // Saturating backpressure counter; a clear request takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 16'h0000;
        end else if (stall_clr) begin
            stall_cycles_r <= 16'h0000;
        end else if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'h0001;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end
`endif

endmodule

// File: tb/tb_std_pair_streamer.sv
// Bench for std_pair_streamer: queue-based pair model checked every cycle plus directed literal checks.
// Define SSIM_STD_STALL_CNT_EN to also exercise the stall counter.
module tb_std_pair_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_x, in_y;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] std_x, std_y;
    logic        std_x_valid, std_y_valid;
    logic        std_x_ready, std_y_ready;
    logic [2:0]  fifo_count;
`ifdef SSIM_STD_STALL_CNT_EN
    logic        stall_clr;
    logic [15:0] stall_cycles;
    int          m_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    std_pair_streamer dut (
        .clk(clk), .rst_n(rst_n),
        .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_ready(in_ready),
        .std_x(std_x), .std_x_valid(std_x_valid), .std_x_ready(std_x_ready),
        .std_y(std_y), .std_y_valid(std_y_valid), .std_y_ready(std_y_ready),
`ifdef SSIM_STD_STALL_CNT_EN
        .stall_clr(stall_clr), .stall_cycles(stall_cycles),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of pairs plus which half of the head has already been delivered.
    logic [31:0] mq_x[$], mq_y[$];
    logic [31:0] pushed_x[$], pushed_y[$], got_x[$], got_y[$];
    bit m_xd, m_yd;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq_x.delete(); mq_y.delete();
            pushed_x.delete(); pushed_y.delete(); got_x.delete(); got_y.delete();
            m_xd = 0; m_yd = 0;
            chk("rst_count", {29'd0, fifo_count}, 32'd0);
            chk("rst_valids", {30'd0, std_x_valid, std_y_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_data", std_x | std_y, 32'd0);
`ifdef SSIM_STD_STALL_CNT_EN
            m_stall = 0;
            chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
`endif
        end else begin
            int  sz;
            bit  ev_x, ev_y, xf, yf, pop, push;
            sz   = mq_x.size();
            ev_x = (sz != 0) && !m_xd;
            ev_y = (sz != 0) && !m_yd;
            chk("m_count", {29'd0, fifo_count}, sz);
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, sz != 4});
            chk("m_x_valid", {31'd0, std_x_valid}, {31'd0, ev_x});
            chk("m_y_valid", {31'd0, std_y_valid}, {31'd0, ev_y});
            chk("m_x_data", std_x, (sz != 0) ? mq_x[0] : 32'd0);
            chk("m_y_data", std_y, (sz != 0) ? mq_y[0] : 32'd0);
`ifdef SSIM_STD_STALL_CNT_EN
            chk("m_stall", {16'd0, stall_cycles}, m_stall);
            if (stall_clr) m_stall = 0;
            else if (((ev_x && !std_x_ready) || (ev_y && !std_y_ready)) && m_stall != 65535) m_stall++;
`endif
            xf   = ev_x && std_x_ready;
            yf   = ev_y && std_y_ready;
            pop  = (sz != 0) && (xf || m_xd) && (yf || m_yd);
            push = in_valid && (sz != 4);
            if (xf) got_x.push_back(std_x);
            if (yf) got_y.push_back(std_y);
            if (pop) begin
                void'(mq_x.pop_front()); void'(mq_y.pop_front());
                m_xd = 0; m_yd = 0;
            end else begin
                m_xd = m_xd || xf;
                m_yd = m_yd || yf;
            end
            if (push) begin
                mq_x.push_back(in_x); mq_y.push_back(in_y);
                pushed_x.push_back(in_x); pushed_y.push_back(in_y);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] x, input logic [31:0] y);
        in_valid = v; in_x = x; in_y = y;
    endtask

    initial begin
        rst_n = 1'b0; set_in(1'b0, 32'd0, 32'd0);
        std_x_ready = 1'b0; std_y_ready = 1'b0;
`ifdef SSIM_STD_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single pair, both channels ready: visible next cycle, popped in that cycle.
        set_in(1'b1, 32'h3F800000, 32'h40000000);
        std_x_ready = 1'b1; std_y_ready = 1'b1;
        tick();
        set_in(1'b0, 32'd0, 32'd0);
        chk("t1_count", {29'd0, fifo_count}, 32'd1);
        chk("t1_valids", {30'd0, std_x_valid, std_y_valid}, 32'd3);
        chk("t1_x", std_x, 32'h3F800000);
        chk("t1_y", std_y, 32'h40000000);
        tick();
        chk("t1_count_after", {29'd0, fifo_count}, 32'd0);

        // Independent readies: x goes first, y held for three cycles.
        std_x_ready = 1'b1; std_y_ready = 1'b0;
        set_in(1'b1, 32'h3F800000, 32'h40000000);
        tick();
        set_in(1'b1, 32'h40400000, 32'h40800000);
        tick();
        set_in(1'b0, 32'd0, 32'd0);
        chk("t2_count", {29'd0, fifo_count}, 32'd2);
        chk("t2_x_dropped", {31'd0, std_x_valid}, 32'd0);
        chk("t2_y_held", std_y, 32'h40000000);
        tick(); tick();
        chk("t2_y_still", {31'd0, std_y_valid}, 32'd1);
        std_y_ready = 1'b1;
        tick();
        chk("t2_next_x", std_x, 32'h40400000);
        chk("t2_next_y", std_y, 32'h40800000);
        chk("t2_next_valids", {30'd0, std_x_valid, std_y_valid}, 32'd3);
        tick();
        chk("t2_empty", {29'd0, fifo_count}, 32'd0);

        // Fill to DEPTH with readies low; fifth offer must be ignored.
        std_x_ready = 1'b0; std_y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h100 + i, 32'h180 + i);
            tick();
        end
        set_in(1'b0, 32'd0, 32'd0);
        chk("t3_full_count", {29'd0, fifo_count}, 32'd4);
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        std_x_ready = 1'b1; std_y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_order_x", std_x, 32'h100 + i);
            chk("t3_order_y", std_y, 32'h180 + i);
            tick();
        end
        chk("t3_drained", {29'd0, fifo_count}, 32'd0);

        // Ten pairs through the wrapping pointers with random independent readies.
        begin
            int  k;
            int  cyc;
            bit  acc;
            k = 0; cyc = 0;
            while ((k < 10 || fifo_count != 3'd0) && cyc < 400) begin
                set_in(k < 10, 32'h200 + k, 32'h300 + k);
                std_x_ready = $urandom_range(0, 1);
                std_y_ready = $urandom_range(0, 1);
                acc = in_valid && in_ready;
                tick();
                if (acc) k++;
                cyc++;
            end
            set_in(1'b0, 32'd0, 32'd0);
            if (cyc >= 400) begin
                n_checks++; n_errors++;
                $display("FAIL t4_timeout: got %0d pairs pushed, count %0d, required 10 and 0", k, fifo_count);
            end
            chk("t4_nx", got_x.size(), pushed_x.size());
            chk("t4_ny", got_y.size(), pushed_y.size());
            for (int i = 0; i < 10; i++) begin
                chk("t4_seq_x", (i < got_x.size()) ? got_x[got_x.size()-10+i] : 32'hDEAD, 32'h200 + i);
                chk("t4_seq_y", (i < got_y.size()) ? got_y[got_y.size()-10+i] : 32'hDEAD, 32'h300 + i);
            end
        end

        // Reset while only the x half of the head pair has gone out.
        std_x_ready = 1'b1; std_y_ready = 1'b0;
        set_in(1'b1, 32'hAAAA0001, 32'hBBBB0001);
        tick();
        set_in(1'b0, 32'd0, 32'd0);
        tick();
        chk("t5_x_done", {30'd0, std_x_valid, std_y_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valids", {30'd0, std_x_valid, std_y_valid}, 32'd0);
        chk("t5_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        std_x_ready = 1'b0;
        set_in(1'b1, 32'hCCCC0002, 32'hDDDD0002);
        tick();
        set_in(1'b0, 32'd0, 32'd0);
        chk("t5_after_valids", {30'd0, std_x_valid, std_y_valid}, 32'd3);
        chk("t5_after_x", std_x, 32'hCCCC0002);
        std_x_ready = 1'b1; std_y_ready = 1'b1;
        tick();
        chk("t5_drained", {29'd0, fifo_count}, 32'd0);

`ifdef SSIM_STD_STALL_CNT_EN
        std_x_ready = 1'b0; std_y_ready = 1'b0;
        stall_clr = 1'b1;
        set_in(1'b1, 32'h11111111, 32'h22222222);
        tick();
        set_in(1'b0, 32'd0, 32'd0);
        stall_clr = 1'b0;
        repeat (5) tick();
        chk("t6_stall5", {16'd0, stall_cycles}, 32'd5);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("t6_clr", {16'd0, stall_cycles}, 32'd0);
        repeat (70000) tick();
        chk("t6_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
        std_x_ready = 1'b1; std_y_ready = 1'b1;
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
